// File: rtl/pipelinecpu_pkg.sv
// Shared definitions for the CPU data-side memory path.
//   state_e   : arbiter sequencing state (IDLE / BUSY)
//   owner_e   : which bus master owns the data-memory port
//   DM_CTRL_W : width of the access size/sign code
//   DM_*      : access size/sign codes carried on dm_ctrl
package pipelinecpu_pkg;

  localparam int DM_CTRL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [DM_CTRL_W-1:0] DM_WORD   = 3'd0;
  localparam logic [DM_CTRL_W-1:0] DM_HALF   = 3'd1;
  localparam logic [DM_CTRL_W-1:0] DM_HALF_U = 3'd2;
  localparam logic [DM_CTRL_W-1:0] DM_BYTE   = 3'd3;
  localparam logic [DM_CTRL_W-1:0] DM_BYTE_U = 3'd4;

endpackage

// File: rtl/dmem_arbiter_arb2_pick.sv
// arb2_pick: combinational two-way pick between req0 and req1.
// Ports:
//   req0, req1 : requests (req0 is the CPU side)
//   last       : 1 when req1 won the most recent completed access
//   gnt0, gnt1 : one-hot (or zero) grant
// Build option DMEM_ARB_RR_EN: when defined, a tie goes to the master that
// did not win last time; otherwise req0 always wins a tie.
module arb2_pick
  import pipelinecpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // pref0 = 1 means req0 takes a tie.
  logic pref0;

`ifdef DMEM_ARB_RR_EN
  assign pref0 = last;
`else
  // Fixed priority: last is still tracked by the caller but never changes the pick.
  assign pref0 = last | 1'b1;
`endif

  assign gnt0 = req0 & (~req1 | pref0);
  assign gnt1 = req1 & (~req0 | ~pref0);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and a DMA / loader master, sequencing each access over MEM_LAT cycles and
// stalling the pipeline while the port is busy or owned by the DMA.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/dm_ctrl : CPU access request and fields
//   cpu_rdata, cpu_stall       : CPU load data (completion cycle only), pipeline stall
//   dma_req/we/addr/wdata/dm_ctrl : DMA access request and fields (held until dma_gnt)
//   dma_gnt, dma_rdata         : DMA completion pulse and its read data
//   mem_en/w/addr/wdata/dm_ctrl : memory-side access
//   mem_rdata                  : memory read data
//   dbg_state                  : current FSM state (0 = IDLE, 1 = BUSY)
// Build option DMEM_ARB_RR_EN: round-robin on contention (default: CPU priority).
//
// Handshake: a master holds its request and fields stable until its access
// completes (CPU: cpu_stall low while cpu_req high; DMA: dma_gnt pulse). An
// access starts in the cycle it is picked and completes MEM_LAT-1 cycles later;
// a requester that drops mid-access has its result discarded.
module dmem_arbiter
  import pipelinecpu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  input  logic [DM_CTRL_W-1:0] cpu_dm_ctrl,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [AW-1:0]        dma_addr,
  input  logic [DW-1:0]        dma_wdata,
  input  logic [DM_CTRL_W-1:0] dma_dm_ctrl,
  output logic                 dma_gnt,
  output logic [DW-1:0]        dma_rdata,
  output logic                 mem_en,
  output logic                 mem_w,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic [DM_CTRL_W-1:0] mem_dm_ctrl,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 dbg_state
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state;
  owner_e        owner;
  owner_e        last;
  logic [CW-1:0] cnt;

  logic   gnt_cpu, gnt_dma;
  logic   any_req;
  owner_e win;
  owner_e cur;
  logic   active, done;
  logic   cpu_sel, dma_sel;
  logic   cpu_done, dma_done;

  arb2_pick u_pick (
    .req0 (cpu_req),
    .req1 (dma_req),
    .last (last == OWN_DMA),
    .gnt0 (gnt_cpu),
    .gnt1 (gnt_dma)
  );

  always_comb begin
    any_req = gnt_cpu | gnt_dma;
    win     = gnt_cpu ? OWN_CPU : OWN_DMA;
    // In IDLE the winner drives the port this very cycle; in BUSY the owner does.
    cur     = (state == BUSY) ? owner : win;
    active  = (state == BUSY) | any_req;
    done    = active & ((state == BUSY) ? (cnt == CNT_LAST) : (MEM_LAT == 1));
    cpu_sel = ~reset & active & (cur == OWN_CPU);
    dma_sel = ~reset & active & (cur == OWN_DMA);
    cpu_done = cpu_sel & done;
    dma_done = dma_sel & done;
  end

  always_comb begin
    mem_en      = cpu_sel | dma_sel;
    mem_w       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_dm_ctrl = '0;
    if (cpu_sel) begin
      mem_w       = cpu_we;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_dm_ctrl = cpu_dm_ctrl;
    end else if (dma_sel) begin
      mem_w       = dma_we;
      mem_addr    = dma_addr;
      mem_wdata   = dma_wdata;
      mem_dm_ctrl = dma_dm_ctrl;
    end
    // Results of an abandoned access are dropped by gating with the live request.
    cpu_stall = ~reset & cpu_req & ~cpu_done;
    cpu_rdata = (cpu_done & cpu_req) ? mem_rdata : '0;
    dma_gnt   = dma_done & dma_req;
    dma_rdata = (dma_done & dma_req) ? mem_rdata : '0;
    dbg_state = ~reset & (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWN_CPU;
      last  <= OWN_DMA;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (MEM_LAT == 1) begin
              last <= win;
            end else begin
              owner <= win;
              cnt   <= CNT_ONE;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= owner;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
